// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-FF input synchronizer, internal oversample tick
// divider and a four-state FSM producing parallel words with valid/frame-error strobes.
module uart_rx #(
   parameter int unsigned ClkFrequency = 50000000,
   parameter int unsigned Baud         = 115200,
   parameter int unsigned Oversampling = 16,
   parameter int unsigned DataBits     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx,
   output logic [DataBits-1:0] data_out,
   output logic                data_valid,
   output logic                frame_err,
   output logic                busy
);

   localparam int unsigned Div  = ClkFrequency / (Baud * Oversampling);
   localparam int unsigned DivW = $clog2(Div) + 1;
   localparam int unsigned ScW  = $clog2(Oversampling);
   localparam int unsigned BcW  = $clog2(DataBits) + 1;

   localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
   localparam logic [ScW-1:0]  ScMid   = ScW'(Oversampling / 2 - 1);
   localparam logic [ScW-1:0]  ScLast  = ScW'(Oversampling - 1);
   localparam logic [BcW-1:0]  BcLast  = BcW'(DataBits - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e state_q, state_d;

   logic                rx_meta_q, rx_s_q;
   logic [DivW-1:0]     div_q, div_d;
   logic                tick;
   logic [ScW-1:0]      sc_q, sc_d;
   logic [BcW-1:0]      bc_q, bc_d;
   logic [DataBits-1:0] shift_q, shift_d;
   logic [DataBits-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                ferr_q, ferr_d;

   // Synchronizer resets to the idle level so reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign tick  = (div_q == DivLast);
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            StIdle: begin
               if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
               if (sc_q == ScMid) state_d = rx_s_q ? StIdle : StData;
            end
            StData: begin
               if (sc_q == ScLast && bc_q == BcLast) state_d = StStop;
            end
            StStop: begin
               if (sc_q == ScLast) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != StIdle);
   end

   always_comb begin
      sc_d    = sc_q;
      bc_d    = bc_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (tick) begin
         case (state_q)
            StIdle: begin
               if (!rx_s_q) sc_d = '0;
            end
            StStart: begin
               if (sc_q == ScMid) begin
                  sc_d = '0;
                  bc_d = '0;
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
            StData: begin
               if (sc_q == ScLast) begin
                  // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
                  shift_d = {rx_s_q, shift_q[DataBits-1:1]};
                  sc_d    = '0;
                  bc_d    = bc_q + 1'b1;
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
            StStop: begin
               if (sc_q == ScLast) begin
                  sc_d = '0;
                  if (rx_s_q) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
            default: begin
               sc_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sc_q    <= '0;
         bc_q    <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sc_q    <= sc_d;
         bc_q    <= bc_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a 16 clk/bit instance (DIV=1) and a default-parameter
// instance, random and directed frames, expected strobes queued by the stimulus side.
module tb_uart_rx;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         start;
      int         lat;
      int         gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic [7:0] data_out_a, data_out_b;
   logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_a[$];
   exp_t exp_b[$];
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   int   last_valid_a = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(
      .ClkFrequency(1600000),
      .Baud        (100000),
      .Oversampling(16),
      .DataBits    (8)
   ) u_dut_a (
      .clk       (clk),
      .rst       (rst_a),
      .rx        (rx_a),
      .data_out  (data_out_a),
      .data_valid(valid_a),
      .frame_err (ferr_a),
      .busy      (busy_a)
   );

   uart_rx u_dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .rx        (rx_b),
      .data_out  (data_out_b),
      .data_valid(valid_b),
      .frame_err (ferr_b),
      .busy      (busy_b)
   );

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      int   d;
      forever begin
         @(negedge clk);
         if (!rst_a && (valid_a || ferr_a)) begin
            chk(!(valid_a && ferr_a), "a_exclusive", int'({valid_a, ferr_a}), 0);
            chk(exp_a.size() != 0, "a_unexpected_strobe", int'({valid_a, ferr_a}), 0);
            if (exp_a.size() != 0) begin
               e = exp_a.pop_front();
               chk(ferr_a == e.err, "a_kind", int'(ferr_a), int'(e.err));
               chk(data_out_a == e.data, "a_data", int'(data_out_a), int'(e.data));
               if (e.lat != 0) begin
                  d = cyc - e.start - e.lat;
                  chk(d >= -1 && d <= 1, "a_latency", cyc - e.start, e.lat);
               end
               if (e.gap != 0) begin
                  d = cyc - last_valid_a - e.gap;
                  chk(d >= -1 && d <= 1, "a_gap", cyc - last_valid_a, e.gap);
               end
            end
            if (valid_a) last_valid_a = cyc;
         end
         if (!rst_b && (valid_b || ferr_b)) begin
            chk(!(valid_b && ferr_b), "b_exclusive", int'({valid_b, ferr_b}), 0);
            chk(exp_b.size() != 0, "b_unexpected_strobe", int'({valid_b, ferr_b}), 0);
            if (exp_b.size() != 0) begin
               e = exp_b.pop_front();
               chk(ferr_b == e.err, "b_kind", int'(ferr_b), int'(e.err));
               chk(data_out_b == e.data, "b_data", int'(data_out_b), int'(e.data));
            end
         end
      end
   endtask

   // 16 clk per bit; a bad stop bit predicts a frame error with data_out unchanged.
   task automatic send_a(input logic [7:0] d, input logic stop, input int idle, input int gap);
      exp_t e;
      e.err   = !stop;
      e.data  = stop ? d : last_a;
      e.start = cyc;
      e.lat   = 154;
      e.gap   = gap;
      if (stop) last_a = d;
      exp_a.push_back(e);
      rx_a = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_a = d[i];
         repeat (16) @(negedge clk);
      end
      rx_a = stop;
      repeat (16) @(negedge clk);
      rx_a = 1'b1;
      repeat (idle) @(negedge clk);
   endtask

   task automatic send_b(input logic [7:0] d, input int period);
      exp_t e;
      e.err   = 1'b0;
      e.data  = d;
      e.start = cyc;
      e.lat   = 0;
      e.gap   = 0;
      last_b  = d;
      exp_b.push_back(e);
      rx_b = 1'b0;
      repeat (period) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_b = d[i];
         repeat (period) @(negedge clk);
      end
      rx_b = 1'b1;
      repeat (2 * period) @(negedge clk);
   endtask

   initial begin
      exp_t       e;
      int         c0;
      int         rise;
      int         fall;
      logic [7:0] d;
      logic       stop;

      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk(data_out_a == 8'h00, "a_rst_data", int'(data_out_a), 0);
      chk(valid_a == 1'b0, "a_rst_valid", int'(valid_a), 0);
      chk(ferr_a == 1'b0, "a_rst_ferr", int'(ferr_a), 0);
      chk(busy_a == 1'b0, "a_rst_busy", int'(busy_a), 0);
      chk(data_out_b == 8'h00, "b_rst_data", int'(data_out_b), 0);
      chk(valid_b == 1'b0, "b_rst_valid", int'(valid_b), 0);
      chk(ferr_b == 1'b0, "b_rst_ferr", int'(ferr_b), 0);
      chk(busy_b == 1'b0, "b_rst_busy", int'(busy_b), 0);
      repeat (10) @(negedge clk);

      send_a(8'hA5, 1'b1, 20, 0);
      send_a(8'h3C, 1'b0, 24, 0);

      // Short low glitch: start check at mid start bit rejects it.
      c0   = cyc;
      rise = -1;
      fall = -1;
      rx_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) rx_a = 1'b1;
         @(negedge clk);
         if (busy_a && rise < 0) rise = cyc;
         if (!busy_a && rise >= 0 && fall < 0) fall = cyc;
      end
      chk(rise >= 0, "a_glitch_busy_rise", rise, 1);
      chk(fall >= 0 && fall - c0 <= 11, "a_glitch_busy_fall", fall - c0, 11);

      send_a(8'h00, 1'b1, 0, 0);
      send_a(8'hFF, 1'b1, 20, 160);

      // Held-low line: two frame errors, released before the third frame's start check.
      e.err   = 1'b1;
      e.data  = last_a;
      e.start = cyc;
      e.gap   = 0;
      e.lat   = 154;
      exp_a.push_back(e);
      e.lat   = 308;
      exp_a.push_back(e);
      rx_a = 1'b0;
      repeat (311) @(negedge clk);
      rx_a = 1'b1;
      repeat (40) @(negedge clk);

      // Frame 0x81 aborted by reset during data bit 4; the sender also gives up.
      d    = 8'h81;
      rx_a = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_a = d[i];
         repeat (16) @(negedge clk);
      end
      rx_a = d[4];
      repeat (8) @(negedge clk);
      chk(busy_a == 1'b1, "a_busy_mid_frame", int'(busy_a), 1);
      rst_a = 1'b1;
      rx_a  = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk(data_out_a == 8'h00, "a_abort_data", int'(data_out_a), 0);
      chk(busy_a == 1'b0, "a_abort_busy", int'(busy_a), 0);
      last_a = 8'h00;
      repeat (30) @(negedge clk);
      send_a(8'h42, 1'b1, 20, 0);

      for (int n = 0; n < 40; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 9) != 0);
         send_a(d, stop, stop ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30)), 0);
      end

      for (int i = 0; i < 2000 && exp_a.size() != 0; i++) @(negedge clk);
      chk(exp_a.size() == 0, "a_drain", exp_a.size(), 0);

      // Default divider (432 clk/bit) against 434 clk/bit stimulus with +/-2% skew.
      repeat (20) @(negedge clk);
      send_b(8'h55, 434);
      send_b(8'($urandom), 434);
      send_b(8'($urandom), 443);
      send_b(8'h55, 425);
      send_b(8'($urandom), 425);

      for (int i = 0; i < 10000 && exp_b.size() != 0; i++) @(negedge clk);
      chk(exp_b.size() == 0, "b_drain", exp_b.size(), 0);
      chk(data_out_b == last_b, "b_final_data", int'(data_out_b), int'(last_b));
      repeat (500) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver: the receive-side counterpart of the team's baud-tick-driven transmit path.
- Converts the asynchronous serial line `rx` (8N1 default, LSB first) into parallel bytes, with a one-cycle valid strobe and a framing-error strobe.
- Contains its own oversample tick divider, a 2-FF input synchronizer and a 4-state FSM.
- Sits between the board RX pin and the consumer logic (FIFO or command decoder).

Parameters:
- ClkFrequency, 50000000, system clock frequency in Hz.
- Baud, 115200, line bit rate.
- Oversampling, 16, ticks per bit period; must be an even value >= 4.
- DataBits, 8, payload bits per frame (5..9).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DataBits  last correctly framed word; held until the next good frame.
- data_valid  output  1  one-clk pulse when data_out updates.
- frame_err  output  1  one-clk pulse when the stop bit samples low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Reset is synchronous, active-high on clk (rst).
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - Synchronizer flops=1, FSM=IDLE, all counters=0.
  - rst asserted mid-frame aborts the frame with no strobes; the partial word is discarded.
- Synchronizer: rx passes through two flops (rx_s); the FSM uses only rx_s, giving 2 clk of input latency.
- Tick divider:
  - DIV = ClkFrequency/(Baud*Oversampling), integer division; default gives 27.
  - Free-running counter 0..DIV-1; `tick` is high for one clk when the count equals DIV-1, then the counter wraps to 0.
  - DIV=1 gives tick every clk.
  - Counter width = clog2(DIV)+1.
- Sample counter `sc` (width clog2(Oversampling)) and bit counter `bc` (width clog2(DataBits)+1) advance only on tick.
- FSM (all transitions occur on a tick cycle only):
  - IDLE: if rx_s==0 then sc<=0 and go START.
  - START: sc increments per tick. When sc==Oversampling/2-1 (mid start bit), rx_s is checked:
    - rx_s==0: sc<=0, bc<=0, go DATA.
    - rx_s==1: glitch, return to IDLE with no strobe.
  - DATA: when sc==Oversampling-1 (mid bit), sample rx_s into shift[MSB] and right-shift, so the word is LSB first; sc<=0 and bc++. After the DataBits-th sample, go STOP. Otherwise sc++.
  - STOP: when sc==Oversampling-1, rx_s is checked, then go IDLE in the same cycle:
    - rx_s==1: data_out<=shift, data_valid=1 for that clk.
    - rx_s==0: frame_err=1, data_out unchanged.
- Back-to-back frames: returning to IDLE at mid-stop allows the next start edge to be detected within the following half bit.
- Break condition: line held low produces a frame_err, then immediately re-enters START. A continuous break produces repeated frame_err, one per frame time, with no data_valid.
- data_valid and frame_err are never high in the same clk; each is high for exactly one clk.
- Latency from rx falling edge to strobe:
  - 2 clk (sync) + up to DIV clk (tick alignment) + (Oversampling/2 + (DataBits+1)*Oversampling) ticks.
  - Default: about 9.5 bit times, i.e. 4104 clk ± 27.
- busy rises on the IDLE->START transition and falls in the clk the FSM returns to IDLE.

Test Plan:
- Bench params ClkFrequency=1600000, Baud=100000, Oversampling=16 give DIV=1 and 16 clk/bit.
  - Send 0xA5 8N1 -> data_out=0xA5 and a single-clk data_valid, 154 ±1 clk after the start edge.
  - frame_err stays 0 throughout.
- Bench params: send 0x3C with the stop bit driven low -> frame_err pulse, data_valid stays 0, data_out retains its prior value.
- Bench params: 5-clk low glitch on idle rx -> busy rises then falls within 11 clk; no strobes.
- Bench params: 0x00 then 0xFF, back-to-back with zero idle gap -> two data_valid pulses, values 0x00 then 0xFF, 160 ±1 clk apart.
- Bench params: assert rst for 1 clk during data bit 4 of 0x81, then send 0x42 -> no strobe for the aborted frame; next data_out=0x42.
- Default params (DIV=27): send 0x55 at 115200 baud (434 clk/bit) -> data_out=0x55.
  - Also inject ±2% bit-period skew on the stimulus -> still received correctly.
